seq_alu: RTL

//  Parametrised, multi-cycle successor to the 8-bit combinational ALU; same 4-bit opcode map.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/seq_alu_if.sv | 33 +++
 rtl/seq_alu_muldiv.sv | 86 ++++++++
 rtl/seq_alu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states,
// multiply/divide mode and the status flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NOT1 = 4'b0111;
    localparam logic [3:0] OP_NOT2 = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL,
        DIV,
        DONE
    } state_t;

    typedef enum logic {
        MD_MUL,
        MD_DIV
    } md_mode_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic dz;
        logic ill;
    } flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between decode, the ALU and writeback.
// master: drives in_valid/opcode/operands; slave: drives in_ready, done, results, flags.
interface seq_alu_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             done;
    logic [WIDTH-1:0] ALU_result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_dz;
    logic             flag_ill;

    modport master (
        output in_valid, opcode, operand1, operand2,
        input  in_ready, done, ALU_result, result_hi,
        input  flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill
    );

    modport slave (
        input  in_valid, opcode, operand1, operand2,
        output in_ready, done, ALU_result, result_hi,
        output flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill
    );

endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one adder.
// Ports: clk, reset, start, mode, a, b in; busy, finish (1-cycle), hi, lo out.
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt_q;
    md_mode_t         mode_q;
    logic             finish_q;

    logic             sub;
    logic [WIDTH:0]   x;
    logic [WIDTH:0]   y;
    logic [WIDTH+1:0] s;
    logic [WIDTH:0]   p;
    logic             ge;

    // One adder: mul adds the multiplicand into acc, div trial-subtracts
    // the divisor from {acc, next dividend bit}. The top carry of the
    // subtract doubles as the "no borrow" (x >= y) indication.
    always_comb begin
        sub = (mode_q == MD_DIV);
        x   = sub ? {acc_q, sr_q[WIDTH-1]} : {1'b0, acc_q};
        y   = {1'b0, m_q};
        s   = {1'b0, x} + {1'b0, y ^ {(WIDTH+1){sub}}}
            + {{(WIDTH+1){1'b0}}, sub};
        ge  = s[WIDTH+1];
        p   = sr_q[0] ? s[WIDTH:0] : {1'b0, acc_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            sr_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            mode_q   <= MD_MUL;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            if (start) begin
                acc_q  <= '0;
                m_q    <= (mode == MD_MUL) ? a : b;
                sr_q   <= (mode == MD_MUL) ? b : a;
                cnt_q  <= CNT_W'(WIDTH);
                mode_q <= mode;
            end else if (cnt_q != '0) begin
                if (mode_q == MD_MUL) begin
                    acc_q <= p[WIDTH:1];
                    sr_q  <= {p[0], sr_q[WIDTH-1:1]};
                end else begin
                    acc_q <= ge ? s[WIDTH-1:0] : x[WIDTH-1:0];
                    sr_q  <= {sr_q[WIDTH-2:0], ge};
                end
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    finish_q <= 1'b1;
                end
            end
        end
    end

    assign busy   = (cnt_q != '0);
    assign finish = finish_q;
    assign hi     = acc_q;
    assign lo     = sr_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: valid/ready input, registered results/flags, done pulse.
// Ports: clk, reset (async, active-high), bus (seq_alu_if.slave).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             accept;
    logic             md_start;
    logic             md_busy;
    logic             md_finish;
    md_mode_t         md_mode;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    logic             load_out;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    flags_t           f_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    flags_t           f_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign md_mode = (bus.opcode == OP_DIV) ? MD_DIV : MD_MUL;
    // Divide by zero never enters the iterative unit.
    assign md_start = accept
        && ((bus.opcode == OP_MUL)
        || ((bus.opcode == OP_DIV) && (bus.operand2 != '0)));

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .mode   (md_mode),
        .a      (bus.operand1),
        .b      (bus.operand2),
        .busy   (md_busy),
        .finish (md_finish),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= bus.opcode;
                a_q  <= bus.operand1;
                b_q  <= bus.operand2;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.opcode == OP_MUL) begin
                        state_d = MUL;
                    end else if (md_start) begin
                        state_d = DIV;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                load_out = 1'b1;
                state_d  = DONE;
            end
            MUL, DIV: begin
                if (md_finish) begin
                    load_out = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_lo = '0;
        r_hi = '0;
        f_d  = '0;
        sum  = {1'b0, a_q} + {1'b0, b_q};
        dif  = {1'b0, a_q} - {1'b0, b_q};
        if (state_q == MUL) begin
            r_lo  = md_lo;
            r_hi  = md_hi;
            f_d.ovf = (md_hi != '0);
        end else if (state_q == DIV) begin
            r_lo = md_lo;
            r_hi = md_hi;
        end else begin
            unique case (1'b1)
                (op_q == OP_ADD): begin
                    r_lo      = sum[WIDTH-1:0];
                    f_d.carry = sum[WIDTH];
                    f_d.ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                             && (r_lo[WIDTH-1] != a_q[WIDTH-1]);
                end
                (op_q == OP_SUB): begin
                    r_lo      = dif[WIDTH-1:0];
                    f_d.carry = dif[WIDTH];
                    f_d.ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                             && (r_lo[WIDTH-1] != a_q[WIDTH-1]);
                end
                (op_q == OP_DIV): begin
                    r_lo   = '1;
                    r_hi   = a_q;
                    f_d.dz = 1'b1;
                end
                (op_q == OP_AND):  r_lo = a_q & b_q;
                (op_q == OP_OR):   r_lo = a_q | b_q;
                (op_q == OP_NOT1): r_lo = ~a_q;
                (op_q == OP_NOT2): r_lo = ~b_q;
                default:           f_d.ill = 1'b1;
            endcase
        end
        f_d.zero = (r_lo == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
            hi_q  <= '0;
            f_q   <= '0;
        end else if (load_out) begin
            res_q <= r_lo;
            hi_q  <= r_hi;
            f_q   <= f_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE) && !md_busy;
    assign bus.done       = (state_q == DONE);
    assign bus.ALU_result = res_q;
    assign bus.result_hi  = hi_q;
    assign bus.flag_zero  = f_q.zero;
    assign bus.flag_carry = f_q.carry;
    assign bus.flag_ovf   = f_q.ovf;
    assign bus.flag_dz    = f_q.dz;
    assign bus.flag_ill   = f_q.ill;

endmodule
